// File: rtl/sha256_host_seq_pkg.sv
// Shared register map and status bit positions for the SHA-256 core and its host sequencer.
package sha256_host_seq_pkg;

  localparam int unsigned ADDR_W       = 7;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned K_W          = 6;
  localparam int unsigned J_W          = 5;
  localparam int unsigned TMO_W        = 10;
  localparam int unsigned MSG_BYTES    = 64;
  localparam int unsigned DIGEST_BYTES = 32;

  localparam logic [ADDR_W-1:0] START_W_MEM_ADDR  = 7'h00;
  localparam logic [ADDR_W-1:0] STATUS_REG        = 7'h50;
  localparam logic [ADDR_W-1:0] DIGEST_START_ADDR = 7'h58;
  localparam logic [TMO_W-1:0]  TIMEOUT           = 10'd1023;

  localparam int unsigned ST_START        = 0;
  localparam int unsigned ST_BITCOIN_MODE = 1;
  localparam int unsigned ST_NONCE_SWEEP  = 2;
  localparam int unsigned ST_COMPLETED    = 7;

  // Status register write value; nonce sweep is never requested by the host.
  function automatic logic [DATA_W-1:0] status_cmd(input logic btc, input logic start);
    logic [DATA_W-1:0] v;
    v                  = '0;
    v[ST_START]        = start;
    v[ST_BITCOIN_MODE] = btc;
    v[ST_NONCE_SWEEP]  = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/sha256_host_seq_if.sv
// Message stream in, digest stream out and the core's byte-wide register port.
interface sha256_host_seq_if;
  import sha256_host_seq_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  logic [ADDR_W-1:0] o_w_addr;
  logic [DATA_W-1:0] o_data8;
  logic              o_we;
  logic [DATA_W-1:0] i_data_mux;
  logic              i_irq;

  modport master (
    input  s_valid, s_data,
    output s_ready,
    output m_valid, m_data, m_last,
    input  m_ready,
    output o_w_addr, o_data8, o_we,
    input  i_data_mux, i_irq
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready,
    input  m_valid, m_data, m_last,
    output m_ready,
    input  o_w_addr, o_data8, o_we,
    output i_data_mux, i_irq
  );

endinterface

// File: rtl/sha256_host_seq.sv
// Host sequencer: loads one 64-byte block into the core, runs it, streams the digest out.
module sha256_host_seq
  import sha256_host_seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_btc_mode,
  sha256_host_seq_if.master bus,
  output logic              o_busy,
  output logic              o_err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_ACK, CLEAR, WAIT_DONE, READ
  } state_t;

  state_t state_q, state_d;

  logic [K_W-1:0]    k_q;
  logic [J_W-1:0]    j_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              btc_q;
  logic              s_ready_q;
  logic              m_valid_q;
  logic              m_last_q;
  logic [DATA_W-1:0] m_data_q;
  logic              busy_q;
  logic              err_q;

  logic [ADDR_W-1:0] w_addr_c;
  logic [DATA_W-1:0] data8_c;
  logic              we_c;
  logic              timeout_c;
  logic              s_fire_c;
  logic              m_slot_c;
  logic              m_done_c;
  logic              in_wait_c;

  assign s_fire_c  = s_ready_q && bus.s_valid;
  assign m_slot_c  = !m_valid_q || bus.m_ready;
  assign m_done_c  = m_valid_q && bus.m_ready && m_last_q;
  assign in_wait_c = (state_q == WAIT_ACK) || (state_q == WAIT_DONE);

  // Next state and the combinational core register port.
  always_comb begin
    state_d   = state_q;
    w_addr_c  = STATUS_REG;
    data8_c   = '0;
    we_c      = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_data_mux[ST_COMPLETED]) state_d = LOAD;
      end
      LOAD: begin
        // Byte 0 lands in the most significant byte of W0.
        w_addr_c = START_W_MEM_ADDR + ADDR_W'(MSG_BYTES - 1) - ADDR_W'(k_q);
        we_c     = bus.s_valid;
        data8_c  = bus.s_data;
        if (s_fire_c && (k_q == K_W'(MSG_BYTES - 1))) state_d = START;
      end
      START: begin
        we_c    = 1'b1;
        data8_c = status_cmd(btc_q, 1'b1);
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!bus.i_data_mux[ST_COMPLETED]) begin
          state_d = CLEAR;
        end else if (tmo_q == TIMEOUT) begin
          timeout_c = 1'b1;
          we_c      = 1'b1;
          state_d   = IDLE;
        end
      end
      CLEAR: begin
        we_c    = 1'b1;
        data8_c = status_cmd(btc_q, 1'b0);
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.i_data_mux[ST_COMPLETED] || bus.i_irq) begin
          state_d = READ;
        end else if (tmo_q == TIMEOUT) begin
          timeout_c = 1'b1;
          we_c      = 1'b1;
          state_d   = IDLE;
        end
      end
      READ: begin
        w_addr_c = DIGEST_START_ADDR + ADDR_W'(DIGEST_BYTES - 1) - ADDR_W'(j_q);
        if (m_done_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered status/handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d == LOAD);
      busy_q    <= (state_d != IDLE);
      err_q     <= timeout_c;
    end
  end

  // Byte counters, mode capture and wait-state timeout counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_q   <= '0;
      btc_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      if ((state_q == LOAD) && s_fire_c) begin
        if (k_q == '0) btc_q <= i_btc_mode;
        if (k_q != K_W'(MSG_BYTES - 1)) k_q <= k_q + K_W'(1);
      end
      if (state_d == IDLE) k_q <= '0;
      if (((state_d == WAIT_ACK) || (state_d == WAIT_DONE)) && (state_d != state_q)) begin
        tmo_q <= '0;
      end else if (in_wait_c) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
    end
  end

  // Digest output skid: refill whenever the output slot is empty or being taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      j_q       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      if ((state_q == READ) && m_slot_c) begin
        if (m_done_c) begin
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
        end else begin
          m_data_q  <= bus.i_data_mux;
          m_valid_q <= 1'b1;
          m_last_q  <= (j_q == J_W'(DIGEST_BYTES - 1));
          if (j_q != J_W'(DIGEST_BYTES - 1)) j_q <= j_q + J_W'(1);
        end
      end
      if (state_d == IDLE) j_q <= '0;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_last   = m_last_q;
  assign bus.o_w_addr = w_addr_c;
  assign bus.o_data8  = data8_c;
  assign bus.o_we     = we_c;
  assign o_busy       = busy_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_sha256_host_seq.sv
// Scoreboard bench for sha256_host_seq against a behavioural core stub.
module tb_sha256_host_seq;
  import sha256_host_seq_pkg::*;

  localparam int CORE_LAT = 20;

  logic i_clk = 1'b0;
  logic i_rst;
  logic core_rst;
  logic i_btc_mode;
  logic o_busy;
  logic o_err;

  sha256_host_seq_if bus();

  sha256_host_seq dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_btc_mode (i_btc_mode),
    .bus        (bus),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Core stub: register file, COMPLETED flag, fixed-latency hash that loads digest_ref.
  logic [7:0] mem [128];
  logic [7:0] digest_ref [32];
  logic [7:0] msg [64];
  logic       completed;
  logic       core_irq;
  logic       running;
  int         run_cnt;
  int         core_mode;  // 0: bit7 + irq, 1: irq only (bit7 later), 2: never acknowledges

  assign bus.i_irq      = core_irq;
  assign bus.i_data_mux = (bus.o_w_addr == STATUS_REG) ? {completed, mem[STATUS_REG][6:0]}
                                                       : mem[bus.o_w_addr];

  always @(posedge i_clk) begin
    core_irq <= 1'b0;
    if (core_rst) begin
      completed <= 1'b1;
      running   <= 1'b0;
      run_cnt   <= 0;
    end else begin
      if (bus.o_we) begin
        mem[bus.o_w_addr] <= bus.o_data8;
        if (bus.o_w_addr == STATUS_REG && bus.o_data8[0] && core_mode != 2) begin
          completed <= 1'b0;
          running   <= 1'b1;
          run_cnt   <= 0;
        end
      end
      if (running) begin
        run_cnt <= run_cnt + 1;
        if (run_cnt == CORE_LAT) begin
          for (int i = 0; i < 32; i++) mem[DIGEST_START_ADDR + 7'(31 - i)] <= digest_ref[i];
          core_irq <= 1'b1;
          if (core_mode == 0) begin
            completed <= 1'b1;
            running   <= 1'b0;
          end
        end
        if (run_cnt == CORE_LAT + 60) begin
          completed <= 1'b1;
          running   <= 1'b0;
        end
      end
    end
  end

  // Digest backpressure.
  logic bp_en = 1'b0;
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      bus.m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic [14:0] exp_w [$];
  logic [8:0]  exp_d [$];

  // Monitor: core writes, digest bytes, stall stability, error pulses.
  logic [14:0] ew;
  logic [8:0]  ed;
  logic        stall_prev = 1'b0;
  logic [7:0]  held_data;
  logic        held_last;
  int          first_msg_cyc = 0;
  int          prev_status_cyc = 0;
  int          last_status_cyc = 0;
  int          err_cnt = 0;
  int          err_cyc = 0;
  logic        err_busy = 1'b0;

  always @(negedge i_clk) begin
    if (bus.o_we) begin
      if (bus.o_w_addr == 7'h3F) first_msg_cyc = cyc;
      if (bus.o_w_addr == STATUS_REG) begin
        prev_status_cyc = last_status_cyc;
        last_status_cyc = cyc;
      end
      checks++;
      if (exp_w.size() == 0) begin
        errors++;
        $display("FAIL core_write: unexpected addr=%02h data=%02h", bus.o_w_addr, bus.o_data8);
      end else begin
        ew = exp_w.pop_front();
        if ({bus.o_w_addr, bus.o_data8} !== ew) begin
          errors++;
          $display("FAIL core_write: got addr=%02h data=%02h, want addr=%02h data=%02h",
                   bus.o_w_addr, bus.o_data8, ew[14:8], ew[7:0]);
        end
      end
    end
    if (stall_prev) begin
      checks++;
      if (!bus.m_valid || bus.m_data !== held_data || bus.m_last !== held_last) begin
        errors++;
        $display("FAIL m_hold: got v=%0b d=%02h l=%0b, want v=1 d=%02h l=%0b",
                 bus.m_valid, bus.m_data, bus.m_last, held_data, held_last);
      end
    end
    stall_prev = bus.m_valid && !bus.m_ready;
    held_data  = bus.m_data;
    held_last  = bus.m_last;
    if (bus.m_valid && bus.m_ready) begin
      checks++;
      if (exp_d.size() == 0) begin
        errors++;
        $display("FAIL digest: unexpected byte %02h last=%0b", bus.m_data, bus.m_last);
      end else begin
        ed = exp_d.pop_front();
        if ({bus.m_last, bus.m_data} !== ed) begin
          errors++;
          $display("FAIL digest: got %02h last=%0b, want %02h last=%0b",
                   bus.m_data, bus.m_last, ed[7:0], ed[8]);
        end
      end
    end
    if (o_err) begin
      err_cnt++;
      err_cyc  = cyc;
      err_busy = o_busy;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic set_digest(input logic [255:0] d);
    for (int i = 0; i < 32; i++) digest_ref[i] = d[255 - 8*i -: 8];
  endtask

  task automatic push_msg(input int n);
    for (int k = 0; k < n; k++) exp_w.push_back({7'(63 - k), msg[k]});
  endtask

  task automatic push_status(input logic [7:0] d);
    exp_w.push_back({STATUS_REG, d});
  endtask

  task automatic push_digest();
    for (int i = 0; i < 32; i++) exp_d.push_back({(i == 31), digest_ref[i]});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_w.size() != 0 || exp_d.size() != 0) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (exp_w.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d writes and %0d digest bytes still pending",
               exp_w.size(), exp_d.size());
      exp_w.delete();
      exp_d.delete();
    end
  endtask

  // Stream msg[] into the DUT; optionally assert reset while byte stop_at is presented.
  task automatic send_block(input int stop_at, input logic btc_first, input logic btc_rest);
    int k = 0;
    int guard = 0;
    @(posedge i_clk);
    #1;
    i_btc_mode  = btc_first;
    bus.s_valid = 1'b1;
    bus.s_data  = msg[0];
    while (k < 64) begin
      if (k == stop_at) i_rst = 1'b1;
      @(negedge i_clk);
      if (k == stop_at) begin
        @(posedge i_clk);
        #1;
        i_rst       = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge i_clk);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_we", 32'(bus.o_we), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_addr", 32'(bus.o_w_addr), 32'h50);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        return;
      end
      if (bus.s_ready) begin
        k++;
      end else begin
        guard++;
        if (guard > 3000) begin
          checks++;
          errors++;
          $display("FAIL s_ready_wait: stalled at byte %0d", k);
          break;
        end
      end
      @(posedge i_clk);
      #1;
      if (k >= 1) i_btc_mode = btc_rest;
      if (k < 64) bus.s_data = msg[k];
    end
    bus.s_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    i_rst       = 1'b1;
    core_rst    = 1'b1;
    i_btc_mode  = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    core_mode   = 0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_s_ready", 32'(bus.s_ready), 32'd0);
    chk("reset_we", 32'(bus.o_we), 32'd0);
    chk("reset_data8", 32'(bus.o_data8), 32'd0);
    chk("reset_addr", 32'(bus.o_w_addr), 32'h50);
    chk("reset_m_valid", 32'(bus.m_valid), 32'd0);
    chk("reset_m_data", 32'(bus.m_data), 32'd0);
    chk("reset_m_last", 32'(bus.m_last), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_err", 32'(o_err), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst    = 1'b0;
    core_rst = 1'b0;

    // "abc" padded block.
    for (int k = 0; k < 64; k++) msg[k] = 8'h00;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h80; msg[63] = 8'h18;
    set_digest(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    push_msg(64);
    push_status(8'h01);
    push_status(8'h00);
    push_digest();
    send_block(-1, 1'b0, 1'b0);
    drain(400);

    // Address mapping with a ramp, digest under random backpressure.
    for (int k = 0; k < 64; k++) msg[k] = 8'(k);
    set_digest(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    push_msg(64);
    push_status(8'h01);
    push_status(8'h00);
    push_digest();
    bp_en = 1'b1;
    send_block(-1, 1'b0, 1'b0);
    drain(800);
    bp_en = 1'b0;
    chk("load_to_start", 32'(prev_status_cyc - first_msg_cyc), 32'd64);

    // Bitcoin mode latched from byte 0 only; completion signalled by irq alone.
    for (int k = 0; k < 64; k++) msg[k] = 8'(255 - k);
    set_digest(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    core_mode = 1;
    push_msg(64);
    push_status(8'h03);
    push_status(8'h02);
    push_digest();
    send_block(-1, 1'b1, 1'b0);
    drain(400);
    core_mode = 0;

    // Reset while byte 20 is presented, then a full block restarting at address 63.
    for (int k = 0; k < 64; k++) msg[k] = 8'(8'h40 + k);
    push_msg(21);
    send_block(20, 1'b0, 1'b0);
    drain(10);
    set_digest(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    push_msg(64);
    push_status(8'h01);
    push_status(8'h00);
    push_digest();
    send_block(-1, 1'b0, 1'b0);
    drain(400);
    chk("no_err_before_timeout", 32'(err_cnt), 32'd0);

    // Core never acknowledges start: timeout, status cleared, no digest.
    for (int k = 0; k < 64; k++) msg[k] = 8'(k) ^ 8'h5A;
    core_mode = 2;
    push_msg(64);
    push_status(8'h01);
    push_status(8'h00);
    e0 = err_cnt;
    send_block(-1, 1'b0, 1'b0);
    drain(1500);
    repeat (3) @(negedge i_clk);
    chk("err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("tmo_cycles", 32'(last_status_cyc - prev_status_cyc), 32'd1024);
    chk("err_after_wr", 32'(err_cyc - last_status_cyc), 32'd1);
    chk("busy_at_err", 32'(err_busy), 32'd0);

    repeat (5) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
